mem_chip_select_seq: RTL and testbench

//  Sequenced, parametrised memory chip-select controller. Decodes a latched bank

---
 rtl/mem_chip_select_seq_if.sv | 28 ++
 rtl/mem_chip_select_seq.sv | 138 +++++++++++++
 tb/tb_mem_chip_select_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_chip_select_seq_if.sv
// Bus between the CPU-side requester and the chip-select sequencer.
// Signal names follow the memory-controller register map used by firmware.
interface mem_chip_select_seq_if #(
    parameter int SEL_WIDTH  = 3,
    parameter int NUM_CHIPS  = 8,
    parameter int WAIT_WIDTH = 4
);
    logic [SEL_WIDTH-1:0]  ctrl_reg;
    logic                  req;
    logic                  write;
    logic [WAIT_WIDTH-1:0] waitStates;
    logic                  busy;
    logic                  ack;
    logic                  selError;
    logic [NUM_CHIPS-1:0]  memorySelectors_;
    logic                  outputEnable_;
    logic                  writeEnable_;

    modport master (
        output ctrl_reg, req, write, waitStates,
        input  busy, ack, selError, memorySelectors_, outputEnable_, writeEnable_
    );

    modport slave (
        input  ctrl_reg, req, write, waitStates,
        output busy, ack, selError, memorySelectors_, outputEnable_, writeEnable_
    );
endinterface

// File: rtl/mem_chip_select_seq.sv
// Sequenced memory chip-select controller: one-hot active-low selects with
// SETUP / STROBE / HOLD / RECOVER timing and programmable wait states.
module mem_chip_select_seq #(
    parameter int SEL_WIDTH    = 3,
    parameter int NUM_CHIPS    = 8,
    parameter int WAIT_WIDTH   = 4,
    parameter int GUARD_CYCLES = 1
) (
    input logic                  clk,
    input logic                  reset_,
    mem_chip_select_seq_if.slave bus
);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LOAD =
        (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;
    localparam logic [SEL_WIDTH:0] NUM_CHIPS_L = (SEL_WIDTH + 1)'(NUM_CHIPS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    function automatic logic [NUM_CHIPS-1:0] sel_decode(input logic [SEL_WIDTH-1:0] bank);
        logic [NUM_CHIPS-1:0] v;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            v[i] = (bank != SEL_WIDTH'(i));
        end
        return v;
    endfunction

    state_t                r_state;
    logic [WAIT_WIDTH-1:0] r_cnt;
    logic [GW-1:0]         r_guard;
    logic                  r_write;
    logic                  r_busy;
    logic                  r_ack;
    logic                  r_sel_err;
    logic [NUM_CHIPS-1:0]  r_sel;
    logic                  r_oe;
    logic                  r_we;

    logic                  w_bank_valid;
    logic [NUM_CHIPS-1:0]  w_sel_decode;

    assign w_bank_valid = ({1'b0, bus.ctrl_reg} < NUM_CHIPS_L);
    assign w_sel_decode = sel_decode(bus.ctrl_reg);

    // Access sequencer; every output is a register so strobes are glitch-free.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_guard   <= '0;
            r_write   <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_sel_err <= 1'b0;
            r_sel     <= '1;
            r_oe      <= 1'b1;
            r_we      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack     <= 1'b0;
                    r_sel_err <= 1'b0;
                    if (bus.req && w_bank_valid) begin
                        // Wait count is captured here so later input changes cannot stretch the strobe.
                        r_write <= bus.write;
                        r_cnt   <= bus.waitStates;
                        r_sel   <= w_sel_decode;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end else if (bus.req) begin
                        r_sel_err <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETUP: begin
                    r_state <= STROBE;
                    if (r_write) begin
                        r_we <= 1'b0;
                    end else begin
                        r_oe <= 1'b0;
                    end
                end
                STROBE: begin
                    if (r_cnt == '0) begin
                        r_oe    <= 1'b1;
                        r_we    <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - WAIT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    r_ack <= 1'b0;
                    r_sel <= '1;
                    if (GUARD_CYCLES == 0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_guard <= GUARD_LOAD;
                        r_state <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (r_guard == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_guard <= r_guard - GW'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_ack     <= 1'b0;
                    r_sel_err <= 1'b0;
                    r_sel     <= '1;
                    r_oe      <= 1'b1;
                    r_we      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy             = r_busy;
    assign bus.ack              = r_ack;
    assign bus.selError         = r_sel_err;
    assign bus.memorySelectors_ = r_sel;
    assign bus.outputEnable_    = r_oe;
    assign bus.writeEnable_     = r_we;
endmodule

// File: tb/tb_mem_chip_select_seq.sv
// Scoreboard bench: a default instance (8 chips, 1 guard cycle) and an
// alternate one (6 chips, 2 guard cycles) checked cycle by cycle.
module tb_mem_chip_select_seq;
    logic clk;
    logic rst_m_n;
    logic rst_a_n;

    mem_chip_select_seq_if #(.SEL_WIDTH(3), .NUM_CHIPS(8), .WAIT_WIDTH(4)) bus_m ();
    mem_chip_select_seq_if #(.SEL_WIDTH(3), .NUM_CHIPS(6), .WAIT_WIDTH(4)) bus_a ();

    mem_chip_select_seq #(.SEL_WIDTH(3), .NUM_CHIPS(8), .WAIT_WIDTH(4), .GUARD_CYCLES(1)) u_main (
        .clk(clk), .reset_(rst_m_n), .bus(bus_m)
    );
    mem_chip_select_seq #(.SEL_WIDTH(3), .NUM_CHIPS(6), .WAIT_WIDTH(4), .GUARD_CYCLES(2)) u_alt (
        .clk(clk), .reset_(rst_a_n), .bus(bus_a)
    );

    typedef struct packed {
        logic [7:0] sel;
        logic       oe;
        logic       we;
        logic       ack;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    logic use_alt  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] sel, input logic oe, input logic we,
                            input logic ack, input logic busy, input logic err);
        exp_t e;
        e.sel = sel; e.oe = oe; e.we = we; e.ack = ack; e.busy = busy; e.err = err;
        sb_q.push_back(e);
    endtask

    // Expected per-cycle outputs for one request, starting the cycle after acceptance.
    task automatic push_txn(input int bank, input logic wr, input int ws,
                            input int guard, input int nchips);
        logic [7:0] s;
        s = 8'hFF;
        if (bank >= nchips) begin
            push_exp(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            push_exp(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
            s[bank] = 1'b0;
            push_exp(s, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i <= ws; i++) push_exp(s, wr, ~wr, 1'b0, 1'b1, 1'b0);
            push_exp(s, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            for (int g = 0; g < guard; g++) push_exp(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            push_exp(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        logic [7:0] sel;
        logic [4:0] ctl;
        if (use_alt) begin
            sel = {2'b11, bus_a.memorySelectors_};
            ctl = {bus_a.outputEnable_, bus_a.writeEnable_, bus_a.ack, bus_a.busy, bus_a.selError};
        end else begin
            sel = bus_m.memorySelectors_;
            ctl = {bus_m.outputEnable_, bus_m.writeEnable_, bus_m.ack, bus_m.busy, bus_m.selError};
        end
        check_eq({tag, " sel"}, {24'd0, sel}, {24'd0, e.sel});
        check_eq({tag, " oe_we_ack_busy_err"}, {27'd0, ctl}, {27'd0, e.oe, e.we, e.ack, e.busy, e.err});
    endtask

    task automatic drain(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check_eq({tag, " scoreboard_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_outputs($sformatf("%s c%0d", tag, i), e);
            end
        end
    endtask

    task automatic drive(input logic alt, input logic [2:0] bank, input logic wr, input logic [3:0] ws);
        @(negedge clk);
        use_alt = alt;
        if (alt) begin
            bus_a.ctrl_reg = bank; bus_a.write = wr; bus_a.waitStates = ws; bus_a.req = 1'b1;
        end else begin
            bus_m.ctrl_reg = bank; bus_m.write = wr; bus_m.waitStates = ws; bus_m.req = 1'b1;
        end
    endtask

    task automatic drop_req();
        bus_m.req = 1'b0;
        bus_a.req = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic alt, input int bank, input logic wr, input int ws);
        drive(alt, 3'(bank), wr, 4'(ws));
        push_txn(bank, wr, ws, alt ? 2 : 1, alt ? 6 : 8);
        drain(tag, 1);
        drop_req();
        drain(tag, sb_q.size());
    endtask

    initial begin
        exp_t rst_e;
        rst_e = '{sel: 8'hFF, oe: 1'b1, we: 1'b1, ack: 1'b0, busy: 1'b0, err: 1'b0};
        rst_m_n = 1'b0;
        rst_a_n = 1'b0;
        bus_m.req = 1'b0; bus_m.ctrl_reg = 3'd0; bus_m.write = 1'b0; bus_m.waitStates = 4'd0;
        bus_a.req = 1'b0; bus_a.ctrl_reg = 3'd0; bus_a.write = 1'b0; bus_a.waitStates = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        use_alt = 1'b0; check_outputs("reset main", rst_e);
        use_alt = 1'b1; check_outputs("reset alt", rst_e);
        @(negedge clk);
        rst_m_n = 1'b1;
        rst_a_n = 1'b1;

        do_txn("rd_b5_ws0", 1'b0, 5, 1'b0, 0);
        do_txn("wr_b0_ws3", 1'b0, 0, 1'b1, 3);
        do_txn("rd_b7_ws15", 1'b0, 7, 1'b0, 15);

        // Back-to-back on the 2-guard instance with req held high.
        drive(1'b1, 3'd2, 1'b0, 4'd0);
        push_txn(2, 1'b0, 0, 2, 6);
        push_txn(3, 1'b0, 0, 2, 6);
        drain("b2b", 1);
        bus_a.ctrl_reg = 3'd3;
        drain("b2b", 6);
        drop_req();
        drain("b2b", sb_q.size());

        do_txn("err_b7", 1'b1, 7, 1'b0, 0);
        do_txn("err_b6", 1'b1, 6, 1'b1, 2);
        do_txn("alt_wr_b5", 1'b1, 5, 1'b1, 1);

        // Inputs changed mid-STROBE must not disturb the access in flight.
        drive(1'b0, 3'd1, 1'b0, 4'd2);
        push_txn(1, 1'b0, 2, 1, 8);
        drain("chg", 1);
        drop_req();
        drain("chg", 1);
        bus_m.ctrl_reg = 3'd4; bus_m.waitStates = 4'd9; bus_m.write = 1'b1;
        drain("chg", sb_q.size());

        // Reset mid-STROBE: outputs must clear before the next clock edge.
        drive(1'b0, 3'd3, 1'b1, 4'd5);
        push_txn(3, 1'b1, 5, 1, 8);
        drain("rst_mid", 1);
        drop_req();
        drain("rst_mid", 2);
        #2;
        rst_m_n = 1'b0;
        #1;
        check_outputs("rst_mid async", rst_e);
        sb_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs("rst_mid held", rst_e);
        end
        @(negedge clk);
        rst_m_n = 1'b1;
        do_txn("after_rst", 1'b0, 6, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
